// File: rtl/fifo_sched_pkg.sv
// Shared types and helpers for the FIFO round-robin output scheduler.
// Lock state enum, round-robin pick and one-hot decode.
package fifo_sched_pkg;

  localparam int MAX_IN = 8;
  localparam int MAX_IW = 3;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_e;

  typedef struct packed {
    logic              found;
    logic [MAX_IW-1:0] idx;
  } pick_t;

  function automatic logic [MAX_IW-1:0] onehot_to_idx(
    input logic [MAX_IN-1:0] oh
  );
    logic [MAX_IW-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_IN; i++)
      if (oh[i]) r = r | MAX_IW'(i);
    return r;
  endfunction

  // Search starts at ptr+1 and wraps modulo n; scanning from the
  // far end lets the nearest requester overwrite earlier hits.
  function automatic pick_t rr_pick(
    input logic [MAX_IN-1:0] req,
    input logic [MAX_IW-1:0] ptr,
    input int                n
  );
    pick_t p;
    int    k;
    p = '0;
    k = 0;
    for (int off = MAX_IN; off >= 1; off--) begin
      if (off <= n) begin
        k = (int'(ptr) + off) % n;
        if (req[k[MAX_IW-1:0]]) begin
          p.found = 1'b1;
          p.idx   = MAX_IW'(k);
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// req_i/ptr_i in, one-hot gnt_o plus valid_o out.
module rr_arbiter
  import fifo_sched_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int IDX_W  = 2
) (
  input  logic [NUM_IN-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [NUM_IN-1:0] gnt_o,
  output logic              valid_o
);

  pick_t p;

  always_comb begin
    p       = rr_pick(MAX_IN'(req_i), MAX_IW'(ptr_i), NUM_IN);
    gnt_o   = '0;
    valid_o = p.found;
    if (p.found) gnt_o[IDX_W'(p.idx)] = 1'b1;
  end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Shares one credited link between NUM_IN scfifos (normal mode).
// Ports: fifo_empty/fifo_q in, fifo_rdreq out, credit_return in; out_* link.
module fifo_rr_scheduler
  import fifo_sched_pkg::*;
#(
  parameter int NUM_IN      = 4,
  parameter int DATA_W      = 32,
  parameter int TAIL_BIT    = 31,
  parameter int PACKET_MODE = 1,
  parameter int CREDITS     = 4,
  parameter int IDX_W       = $clog2(NUM_IN),
  parameter int CRED_W      = $clog2(CREDITS + 1)
) (
  input  logic                     clock,
  input  logic                     aclr_n,
  input  logic [NUM_IN-1:0]        fifo_empty,
  input  logic [NUM_IN*DATA_W-1:0] fifo_q,
  output logic [NUM_IN-1:0]        fifo_rdreq,
  input  logic                     credit_return,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [IDX_W-1:0]         out_src,
  output logic [CRED_W-1:0]        credits,
  output logic                     locked,
  output logic                     credit_err
);

  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CREDITS);

  lock_e               lock_q;
  logic [IDX_W-1:0]    rr_ptr_q;
  logic [IDX_W-1:0]    owner_q;
  logic [IDX_W-1:0]    pend_src_q;
  logic                rd_pend_q;
  logic                out_valid_q;
  logic [DATA_W-1:0]   out_data_q;
  logic [IDX_W-1:0]    out_src_q;
  logic [CRED_W-1:0]   credits_q;
  logic [CRED_W-1:0]   credits_d;
  logic                credit_err_q;

  logic [DATA_W-1:0]   ret_data;
  logic                ret_tail;
  logic                rr_mode;
  logic [NUM_IN-1:0]   arb_gnt;
  logic                arb_vld;
  logic [NUM_IN-1:0]   own_oh;
  logic [NUM_IN-1:0]   cand;
  logic                cand_vld;
  logic                issue;
  logic [IDX_W-1:0]    g;

  assign ret_data = fifo_q[pend_src_q*DATA_W +: DATA_W];
  assign ret_tail = rd_pend_q & ret_data[TAIL_BIT];
  // A returning tail frees the grant in the same cycle.
  assign rr_mode  = (lock_q == UNLOCKED) | ret_tail;

  rr_arbiter #(
    .NUM_IN (NUM_IN),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req_i   (~fifo_empty),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (arb_gnt),
    .valid_o (arb_vld)
  );

  always_comb begin
    own_oh          = '0;
    own_oh[owner_q] = 1'b1;
    cand            = arb_gnt;
    cand_vld        = arb_vld;
    if (!rr_mode) begin
      cand     = own_oh & ~fifo_empty;
      cand_vld = ~fifo_empty[owner_q];
    end
  end

  assign issue      = aclr_n & cand_vld & (|credits_q);
  assign fifo_rdreq = issue ? cand : '0;
  assign g          = IDX_W'(onehot_to_idx(MAX_IN'(cand)));

  always_comb begin
    credits_d = credits_q;
    unique case ({issue, credit_return})
      2'b10: credits_d = credits_q - 1'b1;
      2'b01: if (credits_q != CRED_MAX)
               credits_d = credits_q + 1'b1;
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      lock_q       <= UNLOCKED;
      rr_ptr_q     <= IDX_W'(NUM_IN - 1);
      owner_q      <= '0;
      pend_src_q   <= '0;
      rd_pend_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_src_q    <= '0;
      credits_q    <= CRED_MAX;
      credit_err_q <= 1'b0;
    end else begin
      rd_pend_q   <= issue;
      out_valid_q <= rd_pend_q;
      credits_q   <= credits_d;
      if (issue) begin
        pend_src_q <= g;
        rr_ptr_q   <= g;
        owner_q    <= g;
      end
      if (rd_pend_q) begin
        out_data_q <= ret_data;
        out_src_q  <= pend_src_q;
      end
      if (PACKET_MODE != 0) begin
        if (issue)         lock_q <= LOCKED;
        else if (ret_tail) lock_q <= UNLOCKED;
      end
      if (credit_return && credits_q == CRED_MAX)
        credit_err_q <= 1'b1;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_src    = out_src_q;
  assign credits    = credits_q;
  assign locked     = (lock_q == LOCKED);
  assign credit_err = credit_err_q;

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Directed bench for fifo_rr_scheduler: one per-flit RR instance
// and one packet-mode instance, each fed by modelled normal-mode scfifos.
module tb_fifo_rr_scheduler;

  logic clk = 1'b0;
  logic aclr_n;
  always #5 clk = ~clk;

  logic [3:0]   fe    [2];
  logic [127:0] fq    [2];
  logic [3:0]   rdreq [2];
  logic         cr    [2];
  logic         ov    [2];
  logic [31:0]  od    [2];
  logic [1:0]   os    [2];
  logic [2:0]   cred  [2];
  logic         lk    [2];
  logic         cerr  [2];

  fifo_rr_scheduler #(
    .NUM_IN(4), .DATA_W(32), .TAIL_BIT(31),
    .PACKET_MODE(0), .CREDITS(4), .IDX_W(2), .CRED_W(3)
  ) u_dut_rr (
    .clock(clk), .aclr_n(aclr_n),
    .fifo_empty(fe[0]), .fifo_q(fq[0]), .fifo_rdreq(rdreq[0]),
    .credit_return(cr[0]), .out_valid(ov[0]), .out_data(od[0]),
    .out_src(os[0]), .credits(cred[0]), .locked(lk[0]),
    .credit_err(cerr[0])
  );

  fifo_rr_scheduler #(
    .NUM_IN(4), .DATA_W(32), .TAIL_BIT(31),
    .PACKET_MODE(1), .CREDITS(4), .IDX_W(2), .CRED_W(3)
  ) u_dut_pkt (
    .clock(clk), .aclr_n(aclr_n),
    .fifo_empty(fe[1]), .fifo_q(fq[1]), .fifo_rdreq(rdreq[1]),
    .credit_return(cr[1]), .out_valid(ov[1]), .out_data(od[1]),
    .out_src(os[1]), .credits(cred[1]), .locked(lk[1]),
    .credit_err(cerr[1])
  );

  // scfifo model, showahead off: q loads on the edge that sees rdreq.
  logic [31:0] mem [2][4][64];
  int          wp  [2][4];
  int          rp  [2][4] = '{default: 0};
  logic [31:0] qr  [2][4] = '{default: '0};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++)
        if (rdreq[k][i]) begin
          qr[k][i] <= mem[k][i][rp[k][i]];
          rp[k][i] <= rp[k][i] + 1;
        end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      fe[k] = '0;
      fq[k] = '0;
      for (int i = 0; i < 4; i++) begin
        fe[k][i]          = (wp[k][i] == rp[k][i]);
        fq[k][i*32 +: 32] = qr[k][i];
      end
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int k, input int i, input logic [31:0] d);
    mem[k][i][wp[k][i]] = d;
    wp[k][i]            = wp[k][i] + 1;
  endtask

  task automatic cyc;
    @(negedge clk);
  endtask

  task automatic do_reset;
    aclr_n = 1'b0;
    cr[0]  = 1'b0;
    cr[1]  = 1'b0;
    cyc();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++)
        wp[k][i] = rp[k][i];
  endtask

  task automatic go;
    aclr_n = 1'b1;
    #1;
  endtask

  int n;

  initial begin
    aclr_n = 1'b1;
    cr[0]  = 1'b0;
    cr[1]  = 1'b0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++)
        wp[k][i] = 0;
    #2;

    // per-flit RR, FIFOs 0 and 2 with one flit each
    do_reset();
    push(0, 0, 32'h0000_0A00);
    push(0, 2, 32'h0000_0B02);
    #1;
    check("rst_rdreq", rdreq[0], 4'b0000);
    check("rst_ov",    ov[0],    0);
    check("rst_od",    od[0],    0);
    check("rst_os",    os[0],    0);
    check("rst_cred",  cred[0],  4);
    check("rst_lk",    lk[1],    0);
    check("rst_cerr",  cerr[0],  0);
    go();
    check("t1_c1_rdreq", rdreq[0], 4'b0001);
    check("t1_c1_cred",  cred[0],  4);
    cyc();
    check("t1_c2_rdreq", rdreq[0], 4'b0100);
    check("t1_c2_cred",  cred[0],  3);
    check("t1_c2_ov",    ov[0],    0);
    cyc();
    check("t1_c3_ov",    ov[0],    1);
    check("t1_c3_src",   os[0],    0);
    check("t1_c3_data",  od[0],    32'h0000_0A00);
    check("t1_c3_cred",  cred[0],  2);
    check("t1_c3_rdreq", rdreq[0], 4'b0000);
    cyc();
    check("t1_c4_ov",    ov[0],    1);
    check("t1_c4_src",   os[0],    2);
    check("t1_c4_data",  od[0],    32'h0000_0B02);
    cyc();
    check("t1_c5_ov",    ov[0],    0);

    // credit exhaustion
    do_reset();
    for (int j = 0; j < 6; j++) push(0, 1, 32'h100 + j);
    go();
    n = 0;
    for (int c = 0; c < 8; c++) begin
      if (rdreq[0] == 4'b0010) n++;
      cyc();
    end
    check("t2_issues", n,        4);
    check("t2_cred0",  cred[0],  0);
    check("t2_stall",  rdreq[0], 4'b0000);
    cr[0] = 1'b1;
    cyc();
    cr[0] = 1'b0;
    check("t2_ret_cred",  cred[0],  1);
    check("t2_ret_rdreq", rdreq[0], 4'b0010);
    cyc();
    check("t2_after_cred",  cred[0],  0);
    check("t2_after_rdreq", rdreq[0], 4'b0000);
    check("t2_cerr",        cerr[0],  0);

    // simultaneous issue/return, then saturation
    do_reset();
    for (int j = 0; j < 3; j++) push(0, 3, 32'h301 + j);
    go();
    check("t5_c1_rdreq", rdreq[0], 4'b1000);
    cyc();
    check("t5_c2_cred",  cred[0],  3);
    cyc();
    check("t5_c3_cred",  cred[0],  2);
    check("t5_c3_rdreq", rdreq[0], 4'b1000);
    cr[0] = 1'b1;
    cyc();
    check("t5_simul",    cred[0],  2);
    check("t5_c4_rdreq", rdreq[0], 4'b0000);
    cyc();
    check("t5_c5_cred",  cred[0],  3);
    cyc();
    check("t5_c6_cred",  cred[0],  4);
    check("t5_c6_cerr",  cerr[0],  0);
    cyc();
    check("t5_sat_cred", cred[0],  4);
    check("t5_sat_cerr", cerr[0],  1);
    cr[0] = 1'b0;
    cyc();
    check("t5_sticky",   cerr[0],  1);

    // packet lock: 3-flit packet on FIFO0, 1-flit on FIFO1
    do_reset();
    push(1, 0, 32'h0000_0001);
    push(1, 0, 32'h0000_0002);
    push(1, 0, 32'h8000_0003);
    push(1, 1, 32'h8000_0011);
    go();
    check("t3_c1_rdreq", rdreq[1], 4'b0001);
    check("t3_c1_lk",    lk[1],    0);
    cyc();
    check("t3_c2_rdreq", rdreq[1], 4'b0001);
    check("t3_c2_lk",    lk[1],    1);
    cyc();
    check("t3_c3_rdreq", rdreq[1], 4'b0001);
    check("t3_c3_data",  od[1],    32'h0000_0001);
    cyc();
    check("t3_c4_rdreq", rdreq[1], 4'b0010);
    check("t3_c4_lk",    lk[1],    1);
    check("t3_c4_data",  od[1],    32'h0000_0002);
    cyc();
    check("t3_c5_rdreq", rdreq[1], 4'b0000);
    check("t3_c5_lk",    lk[1],    1);
    check("t3_c5_data",  od[1],    32'h8000_0003);
    check("t3_c5_src",   os[1],    0);
    cyc();
    check("t3_c6_lk",    lk[1],    0);
    check("t3_c6_data",  od[1],    32'h8000_0011);
    check("t3_c6_src",   os[1],    1);

    // lock held while owner is empty
    do_reset();
    push(1, 0, 32'h0000_0021);
    push(1, 1, 32'h8000_0031);
    go();
    check("t4_c1_rdreq", rdreq[1], 4'b0001);
    for (int c = 2; c <= 5; c++) begin
      cyc();
      check("t4_hold_rdreq", rdreq[1], 4'b0000);
      check("t4_hold_lk",    lk[1],    1);
    end
    push(1, 0, 32'h8000_0022);
    #1;
    check("t4_tail_rdreq", rdreq[1], 4'b0001);
    cyc();
    check("t4_next_rdreq", rdreq[1], 4'b0010);
    cyc();
    check("t4_c7_data",    od[1],    32'h8000_0022);
    check("t4_c7_src",     os[1],    0);
    check("t4_c7_lk",      lk[1],    1);
    cyc();
    check("t4_c8_data",    od[1],    32'h8000_0031);
    check("t4_c8_src",     os[1],    1);
    check("t4_c8_lk",      lk[1],    0);

    // reset mid-packet with a read in flight
    do_reset();
    push(1, 2, 32'h0000_0061);
    push(1, 2, 32'h0000_0062);
    push(1, 3, 32'h8000_0081);
    go();
    check("t6_c1_rdreq", rdreq[1], 4'b0100);
    cyc();
    check("t6_c2_rdreq", rdreq[1], 4'b0100);
    check("t6_c2_lk",    lk[1],    1);
    check("t6_c2_cred",  cred[1],  3);
    aclr_n = 1'b0;
    #1;
    check("t6_rst_ov",    ov[1],    0);
    check("t6_rst_lk",    lk[1],    0);
    check("t6_rst_cred",  cred[1],  4);
    check("t6_rst_rdreq", rdreq[1], 4'b0000);
    #1;
    aclr_n = 1'b1;
    #1;
    check("t6_restart",  rdreq[1], 4'b0100);
    cyc();
    check("t6_c3_ov",    ov[1],    0);
    check("t6_c3_lk",    lk[1],    1);
    check("t6_c3_cred",  cred[1],  3);
    cyc();
    check("t6_c4_ov",    ov[1],    1);
    check("t6_c4_data",  od[1],    32'h0000_0062);
    check("t6_c4_src",   os[1],    2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
